interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller with a CPU handshake and a source-acknowledge timeout.
// The lowest pending index is presented to the CPU, then src_ack is held until the source drops its request.
module interrupt_controller #(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 16,
  localparam int IDW = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_50_mhz,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               cpu_ack,
  input  logic               err_clr,
  output logic               cpu_irq,
  output logic [IDW-1:0]     cpu_irq_id,
  output logic [NUM_SRC-1:0] src_ack,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               cpu_irq_nxt;
  logic [IDW-1:0]     id_nxt;
  logic [NUM_SRC-1:0] src_ack_nxt;
  logic               err_nxt;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] id_onehot;
  logic [IDW-1:0]     low_idx;
  logic               held;

  assign pending   = irq_in & irq_mask;
  assign id_onehot = NUM_SRC'(1) << cpu_irq_id;
  assign held      = irq_in[cpu_irq_id];

  // Scan downward so the lowest pending index is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDW'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cpu_irq_nxt = cpu_irq;
    id_nxt      = cpu_irq_id;
    src_ack_nxt = src_ack;
    err_nxt     = timeout_err & ~err_clr;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt   = ASSERT;
          cpu_irq_nxt = 1'b1;
          id_nxt      = low_idx;
        end
      end
      ASSERT: begin
        if (cpu_ack) begin
          state_nxt   = ACK;
          cpu_irq_nxt = 1'b0;
          src_ack_nxt = id_onehot;
          cnt_nxt     = '0;
        end
      end
      ACK: begin
        // A drop on the last allowed cycle still counts as a clean release.
        if (!held) begin
          state_nxt   = IDLE;
          src_ack_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          src_ack_nxt = '0;
          err_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        cpu_irq_nxt = 1'b0;
        src_ack_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50_mhz) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cpu_irq     <= 1'b0;
      cpu_irq_id  <= '0;
      src_ack     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cpu_irq     <= cpu_irq_nxt;
      cpu_irq_id  <= id_nxt;
      src_ack     <= src_ack_nxt;
      timeout_err <= err_nxt;
    end
  end

endmodule
